// File: rtl/pc_sequencer.sv
// Program-counter sequencer with CALL/RET via the shared stack, req/ack timeout and fault halt.
// Optional macro PC_WRAP_EN: pc wraps from INST_CAP-1 to 0 instead of saturating.
module pc_sequencer #(
  parameter int INST_CAP    = 20,
  parameter int PC_W        = 5,
  parameter int DATA_LEN    = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [3:0]          opcode,
  input  logic                z_flag,
  input  logic                s_flag,
  input  logic                stk_empty,
  input  logic                stk_ack,
  input  logic [DATA_LEN-1:0] stk_data_out,
  output logic                stk_pop,
  output logic                stk_push,
  output logic [DATA_LEN-1:0] stk_data_in,
  output logic [PC_W-1:0]     pc,
  output logic                fin_sig,
  output logic                halt,
  output logic                fault
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(INST_CAP - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(ACK_TIMEOUT);
  localparam logic [DATA_LEN:0] TGT_LIMIT = (DATA_LEN + 1)'(INST_CAP);

  localparam logic [3:0] OP_JMP  = 4'b0011;
  localparam logic [3:0] OP_JZ   = 4'b0100;
  localparam logic [3:0] OP_JS   = 4'b0101;
  localparam logic [3:0] OP_CALL = 4'b0110;
  localparam logic [3:0] OP_RET  = 4'b0111;
  localparam logic [3:0] OP_EXIT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_NEXT, S_POP, S_PUSH, S_UPDATE, S_HALT
  } state_t;

  state_t              r_state, w_state_nx;
  logic [PC_W-1:0]     r_pc, w_pc_nx;
  logic                r_pop, w_pop_nx;
  logic                r_push, w_push_nx;
  logic [DATA_LEN-1:0] r_data_in, w_data_in_nx;
  logic                r_fin, w_fin_nx;
  logic                r_halt, w_halt_nx;
  logic                r_fault, w_fault_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [DATA_LEN-1:0] r_target, w_target_nx;
  logic                r_call, w_call_nx;

  logic                w_taken;
  logic [PC_W-1:0]     w_pc_succ;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_tgt_ok;

`ifdef PC_WRAP_EN
  assign w_pc_succ = (r_pc < PC_LAST) ? r_pc + PC_W'(1) : '0;
`else
  assign w_pc_succ = (r_pc < PC_LAST) ? r_pc + PC_W'(1) : r_pc;
`endif

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_tgt_ok  = ({1'b0, r_target} < TGT_LIMIT);

  always_comb begin
    w_taken = 1'b0;
    case (opcode)
      OP_JMP, OP_CALL, OP_RET: w_taken = 1'b1;
      OP_JZ:                   w_taken = z_flag;
      OP_JS:                   w_taken = s_flag;
      default:                 w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_pop_nx     = r_pop;
    w_push_nx    = r_push;
    w_data_in_nx = r_data_in;
    w_fin_nx     = 1'b0;
    w_halt_nx    = r_halt;
    w_fault_nx   = r_fault;
    w_cnt_nx     = r_cnt;
    w_target_nx  = r_target;
    w_call_nx    = r_call;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_call_nx = (opcode == OP_CALL);
          if (opcode == OP_EXIT) begin
            w_state_nx = S_HALT;
            w_halt_nx  = 1'b1;
          end else if (w_taken && stk_empty) begin
            w_state_nx = S_HALT;
            w_halt_nx  = 1'b1;
            w_fault_nx = 1'b1;
          end else if (w_taken) begin
            w_state_nx = S_POP;
            w_pop_nx   = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        w_pc_nx    = w_pc_succ;
        w_fin_nx   = 1'b1;
        w_state_nx = S_IDLE;
      end
      S_POP: begin
        if (stk_ack) begin
          w_pop_nx    = 1'b0;
          w_target_nx = stk_data_out;
          if (r_call) begin
            // return address is the successor of the CALL's own pc
            w_state_nx   = S_PUSH;
            w_push_nx    = 1'b1;
            w_data_in_nx = DATA_LEN'(w_pc_succ);
            w_cnt_nx     = '0;
          end else begin
            w_state_nx = S_UPDATE;
          end
        end else begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc == CNT_LIMIT) begin
            w_pop_nx   = 1'b0;
            w_state_nx = S_HALT;
            w_halt_nx  = 1'b1;
            w_fault_nx = 1'b1;
          end
        end
      end
      S_PUSH: begin
        if (stk_ack) begin
          w_push_nx  = 1'b0;
          w_state_nx = S_UPDATE;
        end else begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc == CNT_LIMIT) begin
            w_push_nx  = 1'b0;
            w_state_nx = S_HALT;
            w_halt_nx  = 1'b1;
            w_fault_nx = 1'b1;
          end
        end
      end
      S_UPDATE: begin
        if (w_tgt_ok) begin
          w_pc_nx    = r_target[PC_W-1:0];
          w_fin_nx   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_HALT;
          w_halt_nx  = 1'b1;
          w_fault_nx = 1'b1;
        end
      end
      S_HALT: begin
        w_state_nx = S_HALT;
      end
      default: begin
        w_state_nx = S_HALT;
        w_halt_nx  = 1'b1;
        w_fault_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_pop     <= 1'b0;
      r_push    <= 1'b0;
      r_data_in <= '0;
      r_fin     <= 1'b0;
      r_halt    <= 1'b0;
      r_fault   <= 1'b0;
      r_cnt     <= '0;
      r_target  <= '0;
      r_call    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_pop     <= w_pop_nx;
      r_push    <= w_push_nx;
      r_data_in <= w_data_in_nx;
      r_fin     <= w_fin_nx;
      r_halt    <= w_halt_nx;
      r_fault   <= w_fault_nx;
      r_cnt     <= w_cnt_nx;
      r_target  <= w_target_nx;
      r_call    <= w_call_nx;
    end
  end

  assign stk_pop     = r_pop;
  assign stk_push    = r_push;
  assign stk_data_in = r_data_in;
  assign pc          = r_pc;
  assign fin_sig     = r_fin;
  assign halt        = r_halt;
  assign fault       = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences, random vs. model.
module tb_pc_sequencer;
  localparam int INST_CAP    = 20;
  localparam int PC_W        = 5;
  localparam int DATA_LEN    = 8;
  localparam int ACK_TIMEOUT = 15;
`ifdef PC_WRAP_EN
  localparam int LASTNX  = 0;
  localparam int LASTNX2 = 1;
`else
  localparam int LASTNX  = 19;
  localparam int LASTNX2 = 19;
`endif

  logic                clk = 1'b0;
  logic                rstn, en, z_flag, s_flag, stk_empty, stk_ack;
  logic [3:0]          opcode;
  logic [DATA_LEN-1:0] stk_data_out;
  logic                stk_pop, stk_push, fin_sig, halt, fault;
  logic [DATA_LEN-1:0] stk_data_in;
  logic [PC_W-1:0]     pc;

  pc_sequencer #(
    .INST_CAP(INST_CAP), .PC_W(PC_W), .DATA_LEN(DATA_LEN), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .opcode(opcode), .z_flag(z_flag), .s_flag(s_flag),
    .stk_empty(stk_empty), .stk_ack(stk_ack), .stk_data_out(stk_data_out),
    .stk_pop(stk_pop), .stk_push(stk_push), .stk_data_in(stk_data_in), .pc(pc),
    .fin_sig(fin_sig), .halt(halt), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [DATA_LEN-1:0] stk_q[$];

  typedef struct {
    logic [3:0] op;
    logic       z, s;
    int         pre, kpop, kpush;
    int         exp_pc, exp_lat;
    bit         exp_halt, exp_fault;
    int         exp_push, exp_popc;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; stk_ack = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  function automatic int succ(input int p);
`ifdef PC_WRAP_EN
    return (p == INST_CAP - 1) ? 0 : p + 1;
`else
    return (p == INST_CAP - 1) ? p : p + 1;
`endif
  endfunction

  // Issues one instruction and plays the stack: ack each request after k wait cycles.
  task automatic run_instr(input logic [3:0] op, input logic z, input logic s,
                           input int kpop, input int kpush, input bit never,
                           output int lat, output int popc, output bit got_fin,
                           output int push_val, output bit both);
    int waitc;
    lat = 0; popc = 0; got_fin = 0; push_val = -1; both = 0; waitc = 0;
    opcode = op; z_flag = z; s_flag = s;
    stk_empty = (stk_q.size() == 0);
    en = 1'b1;
    step();
    lat = 1;
    en = 1'b0;
    while (lat < 60 && !fin_sig && !halt) begin
      stk_ack = 1'b0;
      if (stk_pop && stk_push) both = 1;
      if (stk_pop) begin
        popc++;
        if (!never && waitc == kpop) begin
          stk_ack = 1'b1;
          stk_data_out = (stk_q.size() != 0) ? stk_q.pop_back() : '0;
          waitc = 0;
        end else waitc++;
      end else if (stk_push) begin
        push_val = int'(stk_data_in);
        if (!never && waitc == kpush) begin
          stk_ack = 1'b1;
          stk_q.push_back(stk_data_in);
          waitc = 0;
        end else waitc++;
      end
      stk_empty = (stk_q.size() == 0);
      step();
      lat++;
    end
    stk_ack = 1'b0;
    got_fin = fin_sig;
  endtask

  initial begin
    int lat, popc, push_val, mpc, tgt;
    int e_pc, e_lat, e_push, e_popc;
    bit got_fin, both, taken, e_halt, e_fault;
    logic [3:0] op;
    logic z, s;
    int kp, kq;

    en = 1'b0; opcode = '0; z_flag = 1'b0; s_flag = 1'b0; stk_empty = 1'b1;
    stk_ack = 1'b0; stk_data_out = '0; rstn = 1'b1;

    //          op    z  s  pre kp kq  pc       lat halt flt push    popc
    tbl[0]  = '{4'h1, 0, 0, -1, 0, 0, 1,       2,  0,   0,  -1,     0};
    tbl[1]  = '{4'h1, 0, 0, -1, 0, 0, 2,       2,  0,   0,  -1,     0};
    tbl[2]  = '{4'h1, 0, 0, -1, 0, 0, 3,       2,  0,   0,  -1,     0};
    tbl[3]  = '{4'h8, 0, 0, -1, 0, 0, 4,       2,  0,   0,  -1,     0};
    tbl[4]  = '{4'h4, 0, 0, -1, 0, 0, 5,       2,  0,   0,  -1,     0};
    tbl[5]  = '{4'h4, 1, 0, 12, 2, 0, 12,      5,  0,   0,  -1,     3};
    tbl[6]  = '{4'h3, 0, 0, 7,  0, 0, 7,       3,  0,   0,  -1,     1};
    tbl[7]  = '{4'h6, 0, 0, 15, 0, 1, 15,      5,  0,   0,  8,      1};
    tbl[8]  = '{4'h7, 0, 0, -1, 0, 0, 8,       3,  0,   0,  -1,     1};
    tbl[9]  = '{4'h5, 1, 0, -1, 0, 0, 9,       2,  0,   0,  -1,     0};
    tbl[10] = '{4'h5, 0, 1, 19, 1, 0, 19,      4,  0,   0,  -1,     2};
    tbl[11] = '{4'h6, 0, 0, 3,  0, 0, 3,       4,  0,   0,  LASTNX, 1};
    tbl[12] = '{4'h7, 0, 0, -1, 0, 0, LASTNX,  3,  0,   0,  -1,     1};
    tbl[13] = '{4'h5, 0, 1, 19, 0, 0, 19,      3,  0,   0,  -1,     1};
    tbl[14] = '{4'h2, 0, 0, -1, 0, 0, LASTNX,  2,  0,   0,  -1,     0};
    tbl[15] = '{4'hE, 0, 0, -1, 0, 0, LASTNX2, 2,  0,   0,  -1,     0};
    tbl[16] = '{4'h3, 0, 0, -1, 0, 0, LASTNX2, 1,  1,   1,  -1,     0};

    do_reset();
    chk("rst_pc", int'(pc), 0);
    chk("rst_fin", int'(fin_sig), 0);
    chk("rst_halt", int'(halt), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_pop", int'(stk_pop), 0);
    chk("rst_push", int'(stk_push), 0);
    chk("rst_din", int'(stk_data_in), 0);

    foreach (tbl[i]) begin
      if (tbl[i].pre >= 0) stk_q.push_back(DATA_LEN'(tbl[i].pre));
      run_instr(tbl[i].op, tbl[i].z, tbl[i].s, tbl[i].kpop, tbl[i].kpush, 0,
                lat, popc, got_fin, push_val, both);
      chk($sformatf("vec%0d_pc", i), int'(pc), tbl[i].exp_pc);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_halt", i), int'(halt), int'(tbl[i].exp_halt));
      chk($sformatf("vec%0d_fault", i), int'(fault), int'(tbl[i].exp_fault));
      chk($sformatf("vec%0d_fin", i), int'(got_fin), int'(!tbl[i].exp_halt));
      chk($sformatf("vec%0d_push", i), push_val, tbl[i].exp_push);
      chk($sformatf("vec%0d_popc", i), popc, tbl[i].exp_popc);
      chk($sformatf("vec%0d_both", i), int'(both), 0);
    end

    // halted: en pulses must be ignored
    for (int i = 0; i < 3; i++) begin
      opcode = 4'h1; en = 1'b1;
      step();
      en = 1'b0;
      step();
      chk("halt_pc", int'(pc), LASTNX2);
      chk("halt_sticky", int'(halt), 1);
      chk("halt_fault", int'(fault), 1);
      chk("halt_fin", int'(fin_sig), 0);
      chk("halt_pop", int'(stk_pop), 0);
    end

    // asynchronous reset observed between clock edges
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pc", int'(pc), 0);
    chk("arst_halt", int'(halt), 0);
    chk("arst_fault", int'(fault), 0);
    chk("arst_din", int'(stk_data_in), 0);
    step();
    rstn = 1'b1;
    stk_q.delete();

    // fin_sig is a single-cycle pulse
    run_instr(4'h1, 0, 0, 0, 0, 0, lat, popc, got_fin, push_val, both);
    chk("pulse_fin", int'(got_fin), 1);
    step();
    chk("pulse_fin_low", int'(fin_sig), 0);
    chk("pulse_pc", int'(pc), 1);

    // stack never acknowledges a pop
    stk_q.push_back(8'd5);
    run_instr(4'h3, 0, 0, 0, 0, 1, lat, popc, got_fin, push_val, both);
    chk("to_lat", lat, 1 + ACK_TIMEOUT);
    chk("to_popc", popc, ACK_TIMEOUT);
    chk("to_halt", int'(halt), 1);
    chk("to_fault", int'(fault), 1);
    chk("to_fin", int'(got_fin), 0);
    chk("to_pc", int'(pc), 1);
    step();
    chk("to_pop_low", int'(stk_pop), 0);
    do_reset();
    stk_q.delete();

    // popped target outside the program
    stk_q.push_back(8'd25);
    run_instr(4'h3, 0, 0, 0, 0, 0, lat, popc, got_fin, push_val, both);
    chk("oor_lat", lat, 3);
    chk("oor_halt", int'(halt), 1);
    chk("oor_fault", int'(fault), 1);
    chk("oor_fin", int'(got_fin), 0);
    chk("oor_pc", int'(pc), 0);
    do_reset();
    stk_q.delete();

    // reset while a pop is pending drops the request
    stk_q.push_back(8'd5);
    opcode = 4'h3; stk_empty = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    step();
    chk("mid_pop_high", int'(stk_pop), 1);
    rstn = 1'b0;
    #1;
    chk("mid_pop_drop", int'(stk_pop), 0);
    step();
    rstn = 1'b1;
    stk_q.delete();

    run_instr(4'hF, 0, 0, 0, 0, 0, lat, popc, got_fin, push_val, both);
    chk("exit_lat", lat, 1);
    chk("exit_halt", int'(halt), 1);
    chk("exit_fault", int'(fault), 0);
    chk("exit_fin", int'(got_fin), 0);
    do_reset();

    // random instructions against the reference model
    mpc = 0;
    for (int it = 0; it < 200; it++) begin
      if (stk_q.size() == 0 && $urandom_range(0, 2) != 0)
        stk_q.push_back(DATA_LEN'($urandom_range(0, INST_CAP + 3)));
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h3;
      z = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      kp = $urandom_range(0, 3);
      kq = $urandom_range(0, 3);

      taken = (op == 4'h3) || (op == 4'h6) || (op == 4'h7) ||
              (op == 4'h4 && z) || (op == 4'h5 && s);
      e_push = -1; e_popc = 0; e_halt = 0; e_fault = 0;
      if (op == 4'hF) begin
        e_halt = 1; e_lat = 1; e_pc = mpc;
      end else if (!taken) begin
        e_lat = 2; e_pc = succ(mpc);
      end else if (stk_q.size() == 0) begin
        e_halt = 1; e_fault = 1; e_lat = 1; e_pc = mpc;
      end else begin
        tgt = int'(stk_q[$]);
        e_popc = kp + 1;
        e_lat = 3 + kp;
        if (op == 4'h6) begin
          e_push = succ(mpc);
          e_lat = e_lat + 1 + kq;
        end
        if (tgt < INST_CAP) e_pc = tgt;
        else begin
          e_pc = mpc; e_halt = 1; e_fault = 1;
        end
      end

      run_instr(op, z, s, kp, kq, 0, lat, popc, got_fin, push_val, both);
      chk($sformatf("rnd%0d_op%0h_pc", it, op), int'(pc), e_pc);
      chk($sformatf("rnd%0d_op%0h_lat", it, op), lat, e_lat);
      chk($sformatf("rnd%0d_op%0h_halt", it, op), int'(halt), int'(e_halt));
      chk($sformatf("rnd%0d_op%0h_fault", it, op), int'(fault), int'(e_fault));
      chk($sformatf("rnd%0d_op%0h_fin", it, op), int'(got_fin), int'(!e_halt));
      chk($sformatf("rnd%0d_op%0h_push", it, op), push_val, e_push);
      chk($sformatf("rnd%0d_op%0h_popc", it, op), popc, e_popc);
      chk($sformatf("rnd%0d_op%0h_both", it, op), int'(both), 0);
      if (e_halt) begin
        do_reset();
        mpc = 0;
      end else begin
        mpc = e_pc;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
